// File: rtl/bitlogic_pipe.sv
// bitlogic_pipe: two-stage registered bitwise logic unit with valid/ready handshake,
// zero/parity flags and a count of completed output transfers.
module bitlogic_pipe #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [2:0]       out_op,
    output logic             out_zero,
    output logic             out_parity,
    output logic [15:0]      op_count
);
    logic             s1_valid_q, s1_valid_d;
    logic [2:0]       s1_op_q;
    logic [WIDTH-1:0] s1_a_q, s1_b_q;
    logic             s2_valid_q, s2_valid_d;
    logic [2:0]       s2_op_q;
    logic [WIDTH-1:0] s2_data_q, res_d;
    logic             s2_zero_q, s2_parity_q;
    logic [15:0]      count_q, count_d;
    logic             s2_free, s1_adv, in_xfer, out_xfer;

    assign s2_free  = !s2_valid_q || out_ready;
    assign s1_adv   = s1_valid_q && s2_free;
    assign in_ready = rst_n && (!s1_valid_q || s2_free);
    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = s2_valid_q && out_ready;

    always_comb begin
        res_d = '0;
        case (s1_op_q)
            3'b000: res_d = s1_a_q & s1_b_q;
            3'b001: res_d = s1_a_q | s1_b_q;
            3'b010: res_d = s1_a_q ^ s1_b_q;
            3'b011: res_d = ~(s1_a_q ^ s1_b_q);
            3'b100: res_d = ~(s1_a_q & s1_b_q);
            3'b101: res_d = ~(s1_a_q | s1_b_q);
            3'b110: res_d = ~s1_a_q;
            default: res_d = s1_a_q;
        endcase
    end

    always_comb begin
        s1_valid_d = in_xfer || (s1_valid_q && !s1_adv);
        s2_valid_d = s1_adv || (s2_valid_q && !out_ready);
        count_d    = out_xfer ? count_q + 16'd1 : count_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_op_q     <= '0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s2_valid_q  <= 1'b0;
            s2_op_q     <= '0;
            s2_data_q   <= '0;
            s2_zero_q   <= 1'b1;
            s2_parity_q <= 1'b0;
            count_q     <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            count_q    <= count_d;
            if (in_xfer) begin
                s1_op_q <= in_op;
                s1_a_q  <= in_a;
                s1_b_q  <= in_b;
            end
            if (s1_adv) begin
                s2_op_q     <= s1_op_q;
                s2_data_q   <= res_d;
                s2_zero_q   <= (res_d == '0);
                s2_parity_q <= ^res_d;
            end
        end
    end

    assign out_valid  = s2_valid_q;
    assign out_data   = s2_data_q;
    assign out_op     = s2_op_q;
    assign out_zero   = s2_zero_q;
    assign out_parity = s2_parity_q;
    assign op_count   = count_q;
endmodule
